sub_bytes_engine: RTL and testbench
===================================

Name: sub_bytes_engine

Overview:
- Parametrised, handshaked successor to subByteTransform.
- Applies the AES SubBytes transform, or InvSubBytes for the decrypt path, to one 128-bit state.
- Processes LANES bytes per cycle, so area and latency trade against each other through one parameter.
- Sits between AddRoundKey and ShiftRows in the round datapath and back-pressures both neighbours with valid/ready.

Parameters:
- LANES, 16, S-box instances and bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NPASS, 16/LANES, derived, not overridable. Number of BUSY cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  dataIn/in_inv are valid
- in_ready  output  1  engine can accept a block this cycle
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the block
- dataIn  input  [0:127]  input state; byte i = dataIn[8i:8i+7], so byte 0 is the MSB
- out_valid  output  1  subMat holds a completed result
- out_ready  input  1  downstream accepts the result
- subMat  output  [0:127]  substituted state, same byte order as dataIn
- busy  output  1  high in BUSY

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, cnt = 0, work register = 0, mode = 0.
  - subMat = 0, out_valid = 0, busy = 0.
  - in_ready is forced 0 while rst is low.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from state and out_ready only; it never depends on in_valid.
- Accept = in_valid & in_ready at a rising edge. On accept:
  - work <= dataIn, mode <= in_inv, cnt <= 0, state <= BUSY.
  - This also applies from DONE, giving back-to-back operation.
- BUSY, each cycle:
  - Bytes cnt*LANES .. cnt*LANES+LANES-1 of work pass through the lanes and are written back in place.
  - cnt increments each cycle.
  - On the pass with cnt == NPASS-1: subMat <= fully substituted work (the final lanes' outputs merged in), out_valid <= 1, state <= DONE, cnt <= 0.
- Latency: out_valid rises exactly NPASS edges after the accept edge (LANES=16 gives 1, LANES=1 gives 16).
- DONE:
  - out_valid = 1; subMat is stable until the handshake completes.
  - out_ready = 1 with no new accept: out_valid <= 0, state <= IDLE. subMat keeps its last value.
  - out_ready = 1 with in_valid = 1: the result is retired and the new block is accepted on the same edge, so out_valid drops for NPASS cycles.
  - out_ready = 0: the engine holds DONE indefinitely and in_ready = 0.
- Inputs are ignored while busy:
  - in_valid while BUSY has no effect; in_ready = 0.
  - dataIn and in_inv changes after accept do not affect the result.
- Mode is latched per block. A forward block followed by an inverse block gives correct results for each.
- Reset asserted mid-BUSY or mid-DONE aborts the block; no partial result is ever presented.
- Pure byte substitution: no carries and no cross-byte dependency.

Decomposition:
- aes_pkg holds:
  - SBOX and INV_SBOX as 256-entry byte constant arrays.
  - Localparams STATE_W = 128 and NBYTES = 16.
  - The state enum IDLE/BUSY/DONE.
- Sub-module sbox_lane: combinational, 8-bit in, 8-bit out, with an inv select; generate-instantiated LANES times.
- The top level holds the FSM, counter, work/result registers and lane muxing.

Test Plan:
1. LANES=16, forward: dataIn=001F0E543C4E08596E221B0B4774311A -> subMat=63C0AB20EB2F30CB9F93AF2BA092C7A2, with out_valid high 1 cycle after accept.
2. LANES=1, forward: dataIn=5847088B15B61CBA59D4E2E8CD39DFCE -> subMat=6AA0303D594E9CF4CB48989BBD129E8B, with out_valid exactly 16 edges after accept and busy high for 16 cycles.
3. LANES=4, inverse: in_inv=1, dataIn=1AB4D3AAAB5BBAE80130E9BB2741D29A -> subMat=43C6A9620E57C0C80908EBFE3DF87F37, latency 4.
4. Back-pressure (LANES=2):
   - Hold out_ready=0 for 20 cycles after done -> subMat stable at BC3804205138FF26EEEB9A39B31218A1 for input 7876305470767D23993C375B4B3934F1, and in_ready=0.
   - Then raise out_ready with in_valid=1 carrying B1CA51ED08FC54E104B1C9D3E7B26C20 -> same-edge accept, with next result C874D15530B020F8F2C8DD66943750B7 after 8 edges.
5. Reset mid-BUSY (LANES=1): assert rst low at pass 7 -> out_valid=0, subMat=0 and busy=0 immediately. After release, a fresh block completes in 16 edges with no leftover state.
6. Random: 1000 blocks with random in_inv and random valid/ready gaps, for every legal LANES -> matches the reference model; no output is dropped or duplicated.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: forward/inverse S-box tables, state geometry and engine states.
package aes_pkg;

    localparam int unsigned STATE_W = 128;
    localparam int unsigned NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Entry n is the substitution of byte value n (entry 0 is the leftmost byte).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/sbox_lane.sv
// One combinational byte-substitution lane, forward or inverse S-box selected by i_inv.
module sbox_lane
    import aes_pkg::*;
(
    input  logic       i_inv,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte_c
);

    assign o_byte_c = i_inv ? INV_SBOX[i_byte] : SBOX[i_byte];

endmodule

// File: rtl/sub_bytes_engine.sv
// Handshaked AES (Inv)SubBytes engine: substitutes LANES bytes per cycle over 16/LANES passes.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 16
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [0:STATE_W-1] dataIn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:STATE_W-1] subMat,
    output logic               busy
);

    localparam int unsigned NPASS  = NBYTES / LANES;
    localparam int unsigned CNT_W  = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int unsigned BIDX_W = $clog2(NBYTES);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    state_e                  r_state;
    state_e                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [0:NBYTES-1][7:0]  r_work;
    logic [0:NBYTES-1][7:0]  w_work_next;
    logic [0:NBYTES-1][7:0]  w_work_sub;
    logic                    r_mode;
    logic                    w_mode_next;
    logic [0:STATE_W-1]      r_sub_mat;
    logic [0:STATE_W-1]      w_sub_next;
    logic                    r_out_valid;
    logic                    r_busy;
    logic                    w_accept;
    logic [7:0]              w_lane_in  [LANES];
    logic [7:0]              w_lane_out [LANES];

    // Ready while idle, or while done if the current result leaves this same edge.
    assign in_ready  = rst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign subMat    = r_sub_mat;
    assign busy      = r_busy;

    // Lane l works on byte cnt*LANES + l of the work register.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            w_lane_in[l] = r_work[BIDX_W'(32'(r_cnt) * LANES + l)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_lane u_lane (
            .i_inv    (r_mode),
            .i_byte   (w_lane_in[g]),
            .o_byte_c (w_lane_out[g])
        );
    end

    always_comb begin
        w_work_sub = r_work;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_work_sub[BIDX_W'(32'(r_cnt) * LANES + l)] = w_lane_out[l];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_work_next  = r_work;
        w_mode_next  = r_mode;
        w_sub_next   = r_sub_mat;
        if (w_accept) begin
            w_work_next  = dataIn;
            w_mode_next  = in_inv;
            w_cnt_next   = '0;
            w_state_next = BUSY;
        end else begin
            unique case (r_state)
                BUSY: begin
                    w_work_next = w_work_sub;
                    if (r_cnt == CNT_W'(NPASS - 1)) begin
                        w_sub_next   = w_work_sub;
                        w_cnt_next   = '0;
                        w_state_next = DONE;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_mode      <= 1'b0;
            r_sub_mat   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_work      <= w_work_next;
            r_mode      <= w_mode_next;
            r_sub_mat   <= w_sub_next;
            r_out_valid <= (w_state_next == DONE);
            r_busy      <= (w_state_next == BUSY);
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: one instance per legal LANES, directed vectors plus a scoreboarded random run.
module tb_sub_bytes_engine;

    localparam int NDUT = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v_in_valid  [NDUT];
    logic         v_in_ready  [NDUT];
    logic         v_in_inv    [NDUT];
    logic [0:127] v_data      [NDUT];
    logic         v_out_valid [NDUT];
    logic         v_out_ready [NDUT];
    logic [0:127] v_sub       [NDUT];
    logic         v_busy      [NDUT];

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    always #5 clk = ~clk;

    // Instance g has LANES = 2**g: 1, 2, 4, 8, 16.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_bytes_engine #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v_in_valid[g]),
            .in_ready  (v_in_ready[g]),
            .in_inv    (v_in_inv[g]),
            .dataIn    (v_data[g]),
            .out_valid (v_out_valid[g]),
            .out_ready (v_out_ready[g]),
            .subMat    (v_sub[g]),
            .busy      (v_busy[g])
        );
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box built from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_model();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] iv = 8'h00;
            logic [7:0] s;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) iv = 8'(b);
            end
            s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                   ^ {iv[3:0], iv[7:4]} ^ 8'h63;
            m_fwd[a] = s;
            m_inv[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
        logic [127:0] r = '0;
        logic [127:0] t = d;
        for (int i = 0; i < 16; i++) begin
            r = {r[119:0], (inv ? m_inv[t[127:120]] : m_fwd[t[127:120]])};
            t = t << 8;
        end
        return r;
    endfunction

    task automatic send(input int k, input logic [127:0] d, input logic inv, input string tag);
        @(posedge clk); #1;
        v_in_valid[k] = 1'b1;
        v_data[k]     = d;
        v_in_inv[k]   = inv;
        @(negedge clk);
        check_val({tag, "_in_ready"}, 128'(v_in_ready[k]), 128'(1));
        @(posedge clk); #1;
        v_in_valid[k] = 1'b0;
        v_data[k]     = ~d;
        v_in_inv[k]   = ~inv;
    endtask

    // Called just after the accept edge; counts edges until out_valid appears.
    task automatic wait_result(input int k, input logic [127:0] exp, input int npass, input string tag);
        int lat   = 0;
        int nbusy = 0;
        while (lat <= 40) begin
            @(negedge clk);
            if (v_out_valid[k]) break;
            nbusy += int'(v_busy[k]);
            @(posedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, 128'(lat), 128'(npass));
        check_val({tag, "_busy_cycles"}, 128'(nbusy), 128'(npass));
        check_val({tag, "_data"}, v_sub[k], exp);
    endtask

    task automatic retire(input int k, input logic [127:0] exp, input string tag);
        @(posedge clk); #1;
        v_out_ready[k] = 1'b1;
        @(posedge clk); #1;
        v_out_ready[k] = 1'b0;
        @(negedge clk);
        check_val({tag, "_retired_valid"}, 128'(v_out_valid[k]), 128'(0));
        check_val({tag, "_retired_data"}, v_sub[k], exp);
        check_val({tag, "_retired_ready"}, 128'(v_in_ready[k]), 128'(1));
    endtask

    task automatic rand_lane(input int k, input int nblk);
        logic [127:0] q[$];
        logic [127:0] exp;
        int  sent  = 0;
        int  n_out = 0;
        int  cyc   = 0;
        bit  pend  = 1'b0;
        while ((sent < nblk || q.size() != 0) && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            if (!pend) begin
                v_data[k]   = {$urandom(), $urandom(), $urandom(), $urandom()};
                v_in_inv[k] = 1'($urandom_range(0, 1));
                if (sent < nblk && $urandom_range(0, 3) != 0) pend = 1'b1;
            end
            v_in_valid[k]  = pend;
            v_out_ready[k] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (v_out_valid[k] && v_out_ready[k]) begin
                n_out++;
                if (q.size() != 0) begin
                    exp = q.pop_front();
                    check_val($sformatf("rand_l%0d_blk%0d", 1 << k, n_out), v_sub[k], exp);
                end
            end
            if (v_in_valid[k] && v_in_ready[k]) begin
                q.push_back(ref_sub(v_data[k], v_in_inv[k]));
                sent++;
                pend = 1'b0;
            end
        end
        @(posedge clk); #1;
        v_in_valid[k]  = 1'b0;
        v_out_ready[k] = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (v_out_valid[k]) n_out++;
        end
        check_val($sformatf("rand_l%0d_pending", 1 << k), 128'(q.size()), 128'(0));
        check_val($sformatf("rand_l%0d_outputs", 1 << k), 128'(n_out), 128'(nblk));
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            v_in_valid[k]  = 1'b0;
            v_in_inv[k]    = 1'b0;
            v_data[k]      = '0;
            v_out_ready[k] = 1'b0;
        end
        build_model();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check_val($sformatf("reset_l%0d_valid", 1 << k), 128'(v_out_valid[k]), 128'(0));
            check_val($sformatf("reset_l%0d_busy", 1 << k), 128'(v_busy[k]), 128'(0));
            check_val($sformatf("reset_l%0d_data", 1 << k), v_sub[k], 128'(0));
            check_val($sformatf("reset_l%0d_ready", 1 << k), 128'(v_in_ready[k]), 128'(0));
        end
        rst = 1'b1;

        // LANES=16 forward, single-pass latency.
        send(4, 128'h001F0E543C4E08596E221B0B4774311A, 1'b0, "l16_fwd");
        wait_result(4, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, 1, "l16_fwd");
        retire(4, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, "l16_fwd");

        // LANES=1 forward, sixteen passes.
        send(0, 128'h5847088B15B61CBA59D4E2E8CD39DFCE, 1'b0, "l1_fwd");
        wait_result(0, 128'h6AA0303D594E9CF4CB48989BBD129E8B, 16, "l1_fwd");
        retire(0, 128'h6AA0303D594E9CF4CB48989BBD129E8B, "l1_fwd");

        // LANES=4 inverse.
        send(2, 128'h1AB4D3AAAB5BBAE80130E9BB2741D29A, 1'b1, "l4_inv");
        wait_result(2, 128'h43C6A9620E57C0C80908EBFE3DF87F37, 4, "l4_inv");
        retire(2, 128'h43C6A9620E57C0C80908EBFE3DF87F37, "l4_inv");

        // LANES=8 forward then inverse of the result recovers the plaintext.
        send(3, 128'h001F0E543C4E08596E221B0B4774311A, 1'b0, "l8_fwd");
        wait_result(3, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, 2, "l8_fwd");
        retire(3, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, "l8_fwd");
        send(3, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, 1'b1, "l8_inv");
        wait_result(3, 128'h001F0E543C4E08596E221B0B4774311A, 2, "l8_inv");
        retire(3, 128'h001F0E543C4E08596E221B0B4774311A, "l8_inv");

        // LANES=2 back-pressure, then retire and accept on the same edge.
        send(1, 128'h7876305470767D23993C375B4B3934F1, 1'b0, "l2_bp");
        wait_result(1, 128'hBC3804205138FF26EEEB9A39B31218A1, 8, "l2_bp");
        @(posedge clk); #1;
        v_in_valid[1] = 1'b1;
        v_data[1]     = 128'hB1CA51ED08FC54E104B1C9D3E7B26C20;
        v_in_inv[1]   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val($sformatf("l2_hold%0d_data", i), v_sub[1], 128'hBC3804205138FF26EEEB9A39B31218A1);
            check_val($sformatf("l2_hold%0d_ready", i), 128'(v_in_ready[1]), 128'(0));
            @(posedge clk);
        end
        #1 v_out_ready[1] = 1'b1;
        @(negedge clk);
        check_val("l2_b2b_ready", 128'(v_in_ready[1]), 128'(1));
        check_val("l2_b2b_valid", 128'(v_out_valid[1]), 128'(1));
        @(posedge clk); #1;
        v_out_ready[1] = 1'b0;
        v_in_valid[1]  = 1'b0;
        v_data[1]      = '1;
        v_in_inv[1]    = 1'b1;
        wait_result(1, 128'hC874D15530B020F8F2C8DD66943750B7, 8, "l2_b2b");
        retire(1, 128'hC874D15530B020F8F2C8DD66943750B7, "l2_b2b");

        // LANES=1 reset in the middle of BUSY, then a clean block.
        send(0, 128'h5847088B15B61CBA59D4E2E8CD39DFCE, 1'b0, "l1_abort");
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_val("l1_abort_valid", 128'(v_out_valid[0]), 128'(0));
        check_val("l1_abort_data", v_sub[0], 128'(0));
        check_val("l1_abort_busy", 128'(v_busy[0]), 128'(0));
        check_val("l1_abort_ready", 128'(v_in_ready[0]), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        send(0, 128'h001F0E543C4E08596E221B0B4774311A, 1'b0, "l1_fresh");
        wait_result(0, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, 16, "l1_fresh");
        retire(0, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, "l1_fresh");

        // Random traffic on every LANES in parallel.
        fork
            rand_lane(0, 1000);
            rand_lane(1, 1000);
            rand_lane(2, 1000);
            rand_lane(3, 1000);
            rand_lane(4, 1000);
        join

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
